// File: rtl/alu_pkg.sv
// Shared ALU op codes, default widths and small helpers for the shared-ALU arbiter.
package alu_pkg;

    localparam int unsigned ALU_OP_W   = 4;
    localparam int unsigned ALU_DATA_W = 32;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_e;

    localparam alu_op_e ALU_OP_LAST_LEGAL = ALU_AND;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Shifts only use the low five bits of SrcB.
    function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; unsupported op codes yield zero and flag err.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned OP_WIDTH   = ALU_OP_W,
    parameter int unsigned DATA_WIDTH = ALU_DATA_W
) (
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  err
);

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b;
            ALU_SLT:  result = DATA_WIDTH'($signed(a) < $signed(b));
            ALU_SLTU: result = DATA_WIDTH'(a < b);
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b;
            ALU_SRA:  result = $unsigned($signed(a) >>> b);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant search starting at ptr; pointer state is held by the caller.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   ptr_next
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                ptr_next   = PTR_W'((32'(idx) + 1) % NUM_REQ);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters with a single registered response slot.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned OP_WIDTH   = ALU_OP_W,
    parameter int unsigned DATA_WIDTH = ALU_DATA_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*OP_WIDTH-1:0]     req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]           rsp_result,
    output logic                            rsp_zero,
    output logic                            rsp_err,
    output logic                            busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    slot_state_e             state, state_next;
    logic [PTR_W-1:0]        ptr, ptr_next;
    logic [NUM_REQ-1:0]      grant;
    logic                    drain, accept, enable;
    logic [OP_WIDTH-1:0]     sel_op;
    logic [DATA_WIDTH-1:0]   sel_a, sel_b, alu_b, alu_result;
    logic                    alu_err;

    // Owner consuming this cycle frees the slot for an immediate refill.
    assign drain  = |(rsp_valid & rsp_ready);
    assign enable = rst_n && ((state == SLOT_EMPTY) || drain);
    assign accept = |grant;
    assign req_ready = grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req      (req_valid),
        .enable   (enable),
        .ptr      (ptr),
        .grant    (grant),
        .ptr_next (ptr_next)
    );

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op = req_op[i*OP_WIDTH +: OP_WIDTH];
                sel_a  = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                sel_b  = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign alu_b = is_shift_op(ALU_OP_W'(sel_op)) ? (sel_b & DATA_WIDTH'(32'h1f)) : sel_b;

    alu #(
        .OP_WIDTH   (OP_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .op     (sel_op),
        .a      (sel_a),
        .b      (alu_b),
        .result (alu_result),
        .err    (alu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SLOT_EMPTY: if (accept) state_next = SLOT_FULL;
            SLOT_FULL:  if (drain && !accept) state_next = SLOT_EMPTY;
            default:    state_next = SLOT_EMPTY;
        endcase
    end

    always_comb begin
        busy = (state == SLOT_FULL);
    end

    // Response slot: loaded on accept, held under backpressure, result kept after drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (accept) begin
            rsp_valid  <= grant;
            rsp_result <= alu_result;
            rsp_zero   <= (alu_result == '0);
            rsp_err    <= alu_err;
        end else if (drain) begin
            rsp_valid  <= '0;
        end
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational alu instance between NUM_REQ requesters, e.g. the main integer pipe and the branch/address helper. Each requester has a valid/ready request channel and a valid/ready response channel. Arbitration is round-robin. The ALU result is captured in a single registered response slot, so latency is one cycle when the slot is free.

Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- OP_WIDTH, 4: ALU op-code width.
- DATA_WIDTH, 32: operand and result width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request i present.
- req_ready  out  NUM_REQ  request i accepted this cycle.
- req_op  in  NUM_REQ*OP_WIDTH  ALUControl code for requester i; slice i is bits [i*OP_WIDTH +: OP_WIDTH].
- req_a  in  NUM_REQ*DATA_WIDTH  SrcA for requester i, sliced the same way.
- req_b  in  NUM_REQ*DATA_WIDTH  SrcB for requester i, sliced the same way.
- rsp_valid  out  NUM_REQ  one-hot; response slot holds requester i's result.
- rsp_ready  in  NUM_REQ  requester i consumes the response.
- rsp_result  out  DATA_WIDTH  registered ALU result.
- rsp_zero  out  1  1 iff rsp_result == 0.
- rsp_err  out  1  op code was unsupported (1010..1111).
- busy  out  1  response slot occupied.

Behaviour:
- Reset (rst_n low, async): all rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, busy=0, round-robin pointer=0. req_ready is combinationally 0 while in reset.
- States: EMPTY (slot free) and FULL (slot holds a result). busy = (state==FULL).
- Slot is "available" when state==EMPTY, or when state==FULL and rsp_ready[owner]=1 this cycle (drain and refill in the same cycle; no bubble).
- Grant: when the slot is available, grant the first requester with req_valid=1, searching from pointer, pointer+1, ... mod NUM_REQ. req_ready is one-hot to that requester, all zeros otherwise. req_ready depends combinationally on req_valid and rsp_ready.
- Pointer update: on a grant to requester g, pointer <= (g+1) mod NUM_REQ. No grant leaves the pointer unchanged.
- Accept at edge t: result, zero and err are registered; rsp_valid[g]=1 from t+1. Transition EMPTY->FULL, or FULL->FULL on drain+refill.
- Drain without a new grant: FULL->EMPTY and rsp_valid clears. rsp_result holds its last value.
- Responses are held stable while rsp_valid is set and rsp_ready is 0. rsp_ready of non-owners is ignored.
- ALU operand conditioning: for ops 0010 (sll), 0110 (srl) and 0111 (sra), SrcB is masked to bits [4:0] before the alu. Other ops pass SrcB unmodified.
- Op encoding:
  - 0000 add, 0001 sub, 0010 sll, 0011 slt (signed), 0100 sltu.
  - 0101 xor, 0110 srl, 0111 sra, 1000 or (A|B), 1001 and.
  - slt and sltu produce 1 iff A<B, else 0.
  - All arithmetic wraps modulo 2^DATA_WIDTH.
- Unsupported op: result=0, rsp_zero=1, rsp_err=1. It is still granted and responded to normally.
- rsp_zero is computed from the registered result, never latched stale.
- Simultaneous requests: exactly one grant per cycle. The others hold req_valid until they see req_ready.
- Reset mid-operation drops any pending response; no response is issued after reset deasserts.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum with the ten op codes plus the ALU_OP_LAST_LEGAL constant.
  - Default OP_WIDTH and DATA_WIDTH localparams.
  - Function is_shift_op().
- One sub-module, rr_arbiter: NUM_REQ-wide, inputs req and enable; outputs one-hot grant and the updated pointer.
- Datapath: one instance of the existing alu.
- Top level holds the slot FSM and the response registers.

Test Plan:
- Single request: req0 op=0000 a=5 b=7 -> req_ready[0] same cycle; next cycle rsp_valid=01, rsp_result=12, rsp_zero=0.
- Contention fairness, rsp_ready tied 1: both valid for 4 cycles (req0 sub 9-9, req1 sltu 1<0xFFFFFFFF) -> grants alternate 0,1,0,1.
  - Req0 responses: result 0, zero=1.
  - Req1 responses: result 1.
- Backpressure: req1 response held with rsp_ready[1]=0 for 3 cycles -> rsp_result stable, req_ready=00 throughout. Raising rsp_ready[1] with req0 pending -> same-cycle refill, no bubble.
- Shift masking and sign: sra a=0x80000000 b=0x21 -> 0xC0000000; slt a=0xFFFFFFFF b=1 -> 1.
- Illegal op 1100, a=3 b=4 -> result 0, zero=1, err=1; the next legal op clears err.
- Async reset asserted while FULL and mid-cycle -> rsp_valid and busy drop immediately; pointer=0; no response after release.
